// File: rtl/io_port_peripheral.sv
// Host <-> processor I/O port: an input FIFO, an output FIFO with a drop counter,
// and a one-cycle interrupt pulser with holdoff and a one-deep pending request.
module io_port_peripheral #(
    parameter int DEPTH       = 4,
    parameter int IRQ_HOLDOFF = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_in_valid,
    input  logic [15:0] host_in_data,
    output logic        host_in_ready,
    output logic [15:0] input_port,
    output logic        in_avail,
    input  logic        cpu_in_ack,
    input  logic [15:0] out_port,
    input  logic        cpu_out_valid,
    output logic        host_out_valid,
    output logic [15:0] host_out_data,
    input  logic        host_out_ready,
    output logic [7:0]  out_drop_cnt,
    input  logic        irq_req,
    output logic        interrupt_signal,
    output logic        irq_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (IRQ_HOLDOFF > 1) ? $clog2(IRQ_HOLDOFF) : 1;

    typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} irq_state_e;

    logic [15:0]   in_mem_q [DEPTH];
    logic [AW-1:0] in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic          in_empty, in_full, in_push, in_pop;

    logic [15:0]   out_mem_q [DEPTH];
    logic [AW-1:0] out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          out_empty, out_full, out_push, out_pop, out_drop;

    irq_state_e    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          irq_pending_q, irq_pending_d;
    logic          irq_pulse_q, irq_pulse_d;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        in_empty    = (in_cnt_q == '0);
        in_full     = (in_cnt_q == CW'(DEPTH));
        in_push     = host_in_valid && !in_full;
        in_pop      = cpu_in_ack && !in_empty;
        in_wr_ptr_d = in_push ? in_wr_ptr_q + AW'(1) : in_wr_ptr_q;
        in_rd_ptr_d = in_pop  ? in_rd_ptr_q + AW'(1) : in_rd_ptr_q;
        in_cnt_d    = in_cnt_q;
        if (in_push && !in_pop)      in_cnt_d = in_cnt_q + CW'(1);
        else if (in_pop && !in_push) in_cnt_d = in_cnt_q - CW'(1);
    end

    // A full output FIFO still accepts a word when the host frees a slot in the same cycle.
    always_comb begin
        out_empty    = (out_cnt_q == '0);
        out_full     = (out_cnt_q == CW'(DEPTH));
        out_pop      = host_out_ready && !out_empty;
        out_push     = cpu_out_valid && (!out_full || out_pop);
        out_drop     = cpu_out_valid && out_full && !out_pop;
        out_wr_ptr_d = out_push ? out_wr_ptr_q + AW'(1) : out_wr_ptr_q;
        out_rd_ptr_d = out_pop  ? out_rd_ptr_q + AW'(1) : out_rd_ptr_q;
        out_cnt_d    = out_cnt_q;
        if (out_push && !out_pop)      out_cnt_d = out_cnt_q + CW'(1);
        else if (out_pop && !out_push) out_cnt_d = out_cnt_q - CW'(1);
        drop_cnt_d   = (out_drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        irq_pending_d = irq_pending_q;
        unique case (state_q)
            IDLE: begin
                if (irq_req || irq_pending_q) begin
                    state_d       = ASSERT;
                    irq_pending_d = 1'b0;
                end
            end
            ASSERT: begin
                state_d    = HOLDOFF;
                hold_cnt_d = HW'(IRQ_HOLDOFF - 1);
                if (irq_req) irq_pending_d = 1'b1;
            end
            HOLDOFF: begin
                if (irq_req) irq_pending_d = 1'b1;
                if (hold_cnt_q == '0) state_d = IDLE;
                else                  hold_cnt_d = hold_cnt_q - HW'(1);
            end
            default: state_d = IDLE;
        endcase
        irq_pulse_d = (state_d == ASSERT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_wr_ptr_q   <= '0;
            in_rd_ptr_q   <= '0;
            in_cnt_q      <= '0;
            out_wr_ptr_q  <= '0;
            out_rd_ptr_q  <= '0;
            out_cnt_q     <= '0;
            drop_cnt_q    <= '0;
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            irq_pending_q <= 1'b0;
            irq_pulse_q   <= 1'b0;
        end else begin
            in_wr_ptr_q   <= in_wr_ptr_d;
            in_rd_ptr_q   <= in_rd_ptr_d;
            in_cnt_q      <= in_cnt_d;
            out_wr_ptr_q  <= out_wr_ptr_d;
            out_rd_ptr_q  <= out_rd_ptr_d;
            out_cnt_q     <= out_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            irq_pending_q <= irq_pending_d;
            irq_pulse_q   <= irq_pulse_d;
        end
    end

    // NOTE: storage arrays are not reset; the occupancy counters and empty masking hide stale contents.
    always_ff @(posedge clk) begin
        if (in_push)  in_mem_q[in_wr_ptr_q]   <= host_in_data;
        if (out_push) out_mem_q[out_wr_ptr_q] <= out_port;
    end

    assign host_in_ready    = !in_full;
    assign in_avail         = !in_empty;
    assign input_port       = in_empty ? 16'h0000 : in_mem_q[in_rd_ptr_q];
    assign host_out_valid   = !out_empty;
    assign host_out_data    = out_empty ? 16'h0000 : out_mem_q[out_rd_ptr_q];
    assign out_drop_cnt     = drop_cnt_q;
    assign interrupt_signal = irq_pulse_q;
    assign irq_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_io_port_peripheral.sv
// Bench for io_port_peripheral: directed scenarios plus random traffic, all checked
// every cycle against a queue-and-countdown reference model.
module tb_io_port_peripheral;
    localparam int DEPTH       = 4;
    localparam int IRQ_HOLDOFF = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_in_valid, cpu_in_ack, cpu_out_valid, host_out_ready, irq_req;
    logic [15:0] host_in_data, out_port;
    logic        host_in_ready, in_avail, host_out_valid, interrupt_signal, irq_busy;
    logic [15:0] input_port, host_out_data;
    logic [7:0]  out_drop_cnt;

    io_port_peripheral #(.DEPTH(DEPTH), .IRQ_HOLDOFF(IRQ_HOLDOFF)) dut (
        .clk(clk), .rst(rst),
        .host_in_valid(host_in_valid), .host_in_data(host_in_data), .host_in_ready(host_in_ready),
        .input_port(input_port), .in_avail(in_avail), .cpu_in_ack(cpu_in_ack),
        .out_port(out_port), .cpu_out_valid(cpu_out_valid),
        .host_out_valid(host_out_valid), .host_out_data(host_out_data), .host_out_ready(host_out_ready),
        .out_drop_cnt(out_drop_cnt), .irq_req(irq_req),
        .interrupt_signal(interrupt_signal), .irq_busy(irq_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: FIFOs as queues, interrupt as a busy countdown.
    logic [15:0] ref_in[$];
    logic [15:0] ref_out[$];
    int          ref_drop;
    int          ref_busy_left;
    bit          ref_pend;
    bit          ref_pulse;
    int          pulses[$];
    int          busy_cycles;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        ref_in.delete();
        ref_out.delete();
        ref_drop      = 0;
        ref_busy_left = 0;
        ref_pend      = 0;
        ref_pulse     = 0;
    endtask

    task automatic compare_all();
        check("host_in_ready", 16'(host_in_ready), 16'(ref_in.size() < DEPTH));
        check("in_avail", 16'(in_avail), 16'(ref_in.size() > 0));
        check("input_port", input_port, (ref_in.size() > 0) ? ref_in[0] : 16'h0000);
        check("host_out_valid", 16'(host_out_valid), 16'(ref_out.size() > 0));
        check("host_out_data", host_out_data, (ref_out.size() > 0) ? ref_out[0] : 16'h0000);
        check("out_drop_cnt", 16'(out_drop_cnt), 16'(ref_drop));
        check("interrupt_signal", 16'(interrupt_signal), 16'(ref_pulse));
        check("irq_busy", 16'(irq_busy), 16'(ref_busy_left != 0));
    endtask

    // Advance the model by one edge using the inputs currently driven, then clock and compare.
    task automatic tick();
        bit ip, iq, op, oa;
        if (!rst) begin
            model_reset();
        end else begin
            ip = host_in_valid && (ref_in.size() < DEPTH);
            iq = cpu_in_ack && (ref_in.size() > 0);
            op = host_out_ready && (ref_out.size() > 0);
            oa = cpu_out_valid && ((ref_out.size() < DEPTH) || op);
            if (iq) void'(ref_in.pop_front());
            if (ip) ref_in.push_back(host_in_data);
            if (op) void'(ref_out.pop_front());
            if (oa) ref_out.push_back(out_port);
            else if (cpu_out_valid && ref_drop < 255) ref_drop++;
            if (ref_busy_left == 0) begin
                ref_pulse = irq_req || ref_pend;
                if (ref_pulse) begin
                    ref_busy_left = IRQ_HOLDOFF + 1;
                    ref_pend      = 0;
                end
            end else begin
                ref_pulse = 0;
                if (irq_req) ref_pend = 1;
                ref_busy_left--;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
        if (interrupt_signal) pulses.push_back(cyc);
        if (irq_busy) busy_cycles++;
    endtask

    task automatic idle_inputs();
        host_in_valid = 0; cpu_in_ack = 0; cpu_out_valid = 0; host_out_ready = 0; irq_req = 0;
        host_in_data = '0; out_port = '0;
    endtask

    task automatic drain();
        idle_inputs();
        cpu_in_ack = 1; host_out_ready = 1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        idle_inputs();
        for (int i = 0; i < IRQ_HOLDOFF + 3; i++) tick();
    endtask

    task automatic async_reset();
        rst = 0;
        #1;
        model_reset();
        compare_all();
        tick();
        rst = 1;
    endtask

    initial begin
        logic [15:0] in_words [5];
        int t0;
        in_words[0] = 16'h1111; in_words[1] = 16'h2222; in_words[2] = 16'h3333;
        in_words[3] = 16'h4444; in_words[4] = 16'h5555;

        idle_inputs();
        model_reset();
        rst = 0;
        #3;
        compare_all();
        tick();
        tick();
        rst = 1;

        // Input FIFO fill to full, one extra word refused, then drain past empty.
        host_in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            host_in_data = in_words[i];
            tick();
        end
        host_in_valid = 0;
        check("in_full_ready", 16'(host_in_ready), 16'h0000);
        cpu_in_ack = 1;
        for (int i = 0; i < 5; i++) tick();
        cpu_in_ack = 0;
        check("in_drained", input_port, 16'h0000);

        // Output FIFO overflow with a drop, then the same with a host pop on the fifth word.
        for (int pass = 0; pass < 2; pass++) begin
            cpu_out_valid = 1;
            for (int i = 1; i <= 5; i++) begin
                out_port       = 16'(i);
                host_out_ready = (pass == 1 && i == 5);
                tick();
            end
            idle_inputs();
            check("out_head", host_out_data, (pass == 0) ? 16'h0001 : 16'h0002);
            check("out_drops", 16'(out_drop_cnt), 16'h0001);
            host_out_ready = 1;
            for (int i = 0; i < 5; i++) tick();
            host_out_ready = 0;
        end

        // Single irq_req.
        pulses.delete(); busy_cycles = 0;
        t0 = cyc;
        irq_req = 1; tick(); irq_req = 0;
        for (int i = 0; i < 10; i++) tick();
        check("irq1_count", 16'(pulses.size()), 16'd1);
        if (pulses.size() > 0) check("irq1_time", 16'(pulses[0] - t0), 16'd1);
        check("irq1_busy", 16'(busy_cycles), 16'(IRQ_HOLDOFF + 1));

        // Requests during ASSERT/HOLDOFF merge into one pending pulse.
        pulses.delete();
        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            irq_req = (i == 0 || i == 2 || i == 3);
            tick();
        end
        irq_req = 0;
        check("irq2_count", 16'(pulses.size()), 16'd2);
        if (pulses.size() == 2) begin
            check("irq2_first", 16'(pulses[0] - t0), 16'd1);
            check("irq2_second", 16'(pulses[1] - t0), 16'd7);
        end

        // Continuously held request: pulses IRQ_HOLDOFF+2 edges apart.
        pulses.delete();
        irq_req = 1;
        for (int i = 0; i < 20; i++) tick();
        irq_req = 0;
        check("irq_held_count", 16'(pulses.size() >= 3), 16'd1);
        if (pulses.size() >= 2) check("irq_held_period", 16'(pulses[1] - pulses[0]), 16'(IRQ_HOLDOFF + 2));
        drain();

        // Reset mid-pulse with two entries in each FIFO, then push right after release.
        host_in_valid = 1; cpu_out_valid = 1;
        for (int i = 0; i < 2; i++) begin
            host_in_data = 16'hC000 + 16'(i); out_port = 16'hD000 + 16'(i);
            tick();
        end
        idle_inputs();
        irq_req = 1; tick(); irq_req = 0;
        check("pre_reset_pulse", 16'(interrupt_signal), 16'h0001);
        async_reset();
        host_in_valid = 1; host_in_data = 16'hBEEF;
        tick();
        host_in_valid = 0;
        check("post_reset_push", input_port, 16'hBEEF);
        drain();

        // Simultaneous push and pop with two entries present.
        host_in_valid = 1;
        for (int i = 0; i < 2; i++) begin
            host_in_data = 16'h0B01 + 16'(i);
            tick();
        end
        host_in_data = 16'hAAAA; cpu_in_ack = 1;
        tick();
        host_in_valid = 0;
        check("simul_head", input_port, 16'h0B02);
        tick();
        check("simul_tail", input_port, 16'hAAAA);
        drain();

        // Drop counter saturation.
        cpu_out_valid = 1;
        for (int i = 0; i < 270; i++) begin
            out_port = 16'($urandom);
            tick();
        end
        check("drop_saturated", 16'(out_drop_cnt), 16'd255);
        async_reset();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            host_in_valid  = ($urandom_range(0, 2) != 0);
            host_in_data   = 16'($urandom);
            cpu_in_ack     = ($urandom_range(0, 2) == 0);
            cpu_out_valid  = ($urandom_range(0, 1) == 1);
            out_port       = 16'($urandom);
            host_out_ready = ($urandom_range(0, 2) == 0);
            irq_req        = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) async_reset();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
